// File: rtl/ex_stage.sv
// Execute stage of the 5-stage MIPS pipeline: operand forwarding, ALU and the
// EX/MEM pipeline register with stall (hold) and flush (bubble) control.
module ex_stage #(
  parameter int DW = 32,
  parameter int RW = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          id_valid,
  input  logic [DW-1:0] id_rs_data,
  input  logic [DW-1:0] id_rt_data,
  input  logic [DW-1:0] id_imm,
  input  logic [4:0]    id_shamt,
  input  logic [RW-1:0] id_rs,
  input  logic [RW-1:0] id_rt,
  input  logic [RW-1:0] id_wreg,
  input  logic [2:0]    id_alu_ctrl,
  input  logic          id_alusrc,
  input  logic          id_regwrite,
  input  logic          id_memread,
  input  logic          id_memwrite,
  input  logic          id_memtoreg,
  input  logic          wb_regwrite,
  input  logic [RW-1:0] wb_wreg,
  input  logic [DW-1:0] wb_data,
  input  logic          stall,
  input  logic          flush,
  output logic          exmem_valid,
  output logic          exmem_regwrite,
  output logic          exmem_memread,
  output logic          exmem_memwrite,
  output logic          exmem_memtoreg,
  output logic [DW-1:0] exmem_alu_result,
  output logic [DW-1:0] exmem_store_data,
  output logic [RW-1:0] exmem_wreg,
  output logic          exmem_zero
);

  logic          r_valid;
  logic          r_regwrite;
  logic          r_memread;
  logic          r_memwrite;
  logic          r_memtoreg;
  logic [DW-1:0] r_alu_result;
  logic [DW-1:0] r_store_data;
  logic [RW-1:0] r_wreg;
  logic          r_zero;

  logic          w_exmem_fwd_ok;
  logic          w_wb_fwd_ok;
  logic [DW-1:0] w_fwd_a;
  logic [DW-1:0] w_fwd_b;
  logic [DW-1:0] w_alu_b;
  logic [DW-1:0] w_result;

  // A load's EX/MEM result is an address, not data, so it must never forward.
  assign w_exmem_fwd_ok = r_valid && r_regwrite && !r_memread && (r_wreg != '0);
  assign w_wb_fwd_ok    = wb_regwrite && (wb_wreg != '0);

  always_comb begin
    w_fwd_a = id_rs_data;
    if (w_exmem_fwd_ok && (r_wreg == id_rs)) begin
      w_fwd_a = r_alu_result;
    end else if (w_wb_fwd_ok && (wb_wreg == id_rs)) begin
      w_fwd_a = wb_data;
    end
  end

  always_comb begin
    w_fwd_b = id_rt_data;
    if (w_exmem_fwd_ok && (r_wreg == id_rt)) begin
      w_fwd_b = r_alu_result;
    end else if (w_wb_fwd_ok && (wb_wreg == id_rt)) begin
      w_fwd_b = wb_data;
    end
  end

  assign w_alu_b = id_alusrc ? id_imm : w_fwd_b;

  // Shifts always take the register operand, independent of alusrc.
  always_comb begin
    w_result = '0;
    case (id_alu_ctrl)
      3'b010:  w_result = w_fwd_a + w_alu_b;
      3'b110:  w_result = w_fwd_a - w_alu_b;
      3'b000:  w_result = w_fwd_a & w_alu_b;
      3'b001:  w_result = w_fwd_a | w_alu_b;
      3'b111:  w_result = w_fwd_b << id_shamt;
      3'b011:  w_result = w_fwd_b >> id_shamt;
      default: w_result = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid      <= 1'b0;
      r_regwrite   <= 1'b0;
      r_memread    <= 1'b0;
      r_memwrite   <= 1'b0;
      r_memtoreg   <= 1'b0;
      r_alu_result <= '0;
      r_store_data <= '0;
      r_wreg       <= '0;
      r_zero       <= 1'b0;
    end else if (flush) begin
      r_valid      <= 1'b0;
      r_regwrite   <= 1'b0;
      r_memread    <= 1'b0;
      r_memwrite   <= 1'b0;
      r_memtoreg   <= 1'b0;
      r_alu_result <= '0;
      r_store_data <= '0;
      r_wreg       <= '0;
      r_zero       <= 1'b0;
    end else if (!stall) begin
      r_valid      <= id_valid;
      r_regwrite   <= id_regwrite & id_valid;
      r_memread    <= id_memread & id_valid;
      r_memwrite   <= id_memwrite & id_valid;
      r_memtoreg   <= id_memtoreg & id_valid;
      r_alu_result <= w_result;
      r_store_data <= w_fwd_b;
      r_wreg       <= id_wreg;
      r_zero       <= (w_result == '0);
    end
  end

  assign exmem_valid      = r_valid;
  assign exmem_regwrite   = r_regwrite;
  assign exmem_memread    = r_memread;
  assign exmem_memwrite   = r_memwrite;
  assign exmem_memtoreg   = r_memtoreg;
  assign exmem_alu_result = r_alu_result;
  assign exmem_store_data = r_store_data;
  assign exmem_wreg       = r_wreg;
  assign exmem_zero       = r_zero;

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: directed scenarios plus randomized traffic,
// all compared against a behavioural model of the EX/MEM register.
module tb_ex_stage;

  localparam int DW = 32;
  localparam int RW = 5;

  logic          clk;
  logic          rst_n;
  logic          id_valid;
  logic [DW-1:0] id_rs_data, id_rt_data, id_imm;
  logic [4:0]    id_shamt;
  logic [RW-1:0] id_rs, id_rt, id_wreg;
  logic [2:0]    id_alu_ctrl;
  logic          id_alusrc, id_regwrite, id_memread, id_memwrite, id_memtoreg;
  logic          wb_regwrite;
  logic [RW-1:0] wb_wreg;
  logic [DW-1:0] wb_data;
  logic          stall, flush;
  logic          exmem_valid, exmem_regwrite, exmem_memread, exmem_memwrite, exmem_memtoreg;
  logic [DW-1:0] exmem_alu_result, exmem_store_data;
  logic [RW-1:0] exmem_wreg;
  logic          exmem_zero;

  int total = 0;
  int bad   = 0;

  // Reference copy of what the EX/MEM register should contain.
  logic          mValid, mRegwrite, mMemread, mMemwrite, mMemtoreg, mZero;
  logic [DW-1:0] mResult, mStore;
  logic [RW-1:0] mWreg;

  ex_stage #(.DW(DW), .RW(RW)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_shamt(id_shamt), .id_rs(id_rs), .id_rt(id_rt), .id_wreg(id_wreg),
    .id_alu_ctrl(id_alu_ctrl), .id_alusrc(id_alusrc), .id_regwrite(id_regwrite),
    .id_memread(id_memread), .id_memwrite(id_memwrite), .id_memtoreg(id_memtoreg),
    .wb_regwrite(wb_regwrite), .wb_wreg(wb_wreg), .wb_data(wb_data),
    .stall(stall), .flush(flush),
    .exmem_valid(exmem_valid), .exmem_regwrite(exmem_regwrite),
    .exmem_memread(exmem_memread), .exmem_memwrite(exmem_memwrite),
    .exmem_memtoreg(exmem_memtoreg), .exmem_alu_result(exmem_alu_result),
    .exmem_store_data(exmem_store_data), .exmem_wreg(exmem_wreg),
    .exmem_zero(exmem_zero)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [DW-1:0] refOperand(input logic [RW-1:0] r, input logic [DW-1:0] d);
    if (r == 0) return d;
    if (mValid && mRegwrite && !mMemread && mWreg == r) return mResult;
    if (wb_regwrite && wb_wreg == r) return wb_data;
    return d;
  endfunction

  function automatic logic [DW-1:0] refAlu(input logic [2:0] code, input logic [DW-1:0] a,
                                           input logic [DW-1:0] b, input logic [DW-1:0] rt,
                                           input logic [4:0] sh);
    case (code)
      3'b010:  return a + b;
      3'b110:  return a - b;
      3'b000:  return a & b;
      3'b001:  return a | b;
      3'b111:  return rt << sh;
      3'b011:  return rt >> sh;
      default: return '0;
    endcase
  endfunction

  task automatic modelClear();
    {mValid, mRegwrite, mMemread, mMemwrite, mMemtoreg, mZero} = '0;
    mResult = '0;
    mStore  = '0;
    mWreg   = '0;
  endtask

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input string tag);
    chk({tag, ".valid"}, DW'(exmem_valid),    DW'(mValid));
    chk({tag, ".rw"},    DW'(exmem_regwrite), DW'(mRegwrite));
    chk({tag, ".mr"},    DW'(exmem_memread),  DW'(mMemread));
    chk({tag, ".mw"},    DW'(exmem_memwrite), DW'(mMemwrite));
    chk({tag, ".mt"},    DW'(exmem_memtoreg), DW'(mMemtoreg));
    chk({tag, ".res"},   exmem_alu_result,    mResult);
    chk({tag, ".sd"},    exmem_store_data,    mStore);
    chk({tag, ".wreg"},  DW'(exmem_wreg),     DW'(mWreg));
    chk({tag, ".zero"},  DW'(exmem_zero),     DW'(mZero));
  endtask

  // One clock: predict from pre-edge inputs and model state, then compare after the edge.
  task automatic applyStimulus(input string tag);
    logic [DW-1:0] a, b, res;
    a   = refOperand(id_rs, id_rs_data);
    b   = refOperand(id_rt, id_rt_data);
    res = refAlu(id_alu_ctrl, a, id_alusrc ? id_imm : b, b, id_shamt);
    @(posedge clk);
    if (flush) begin
      modelClear();
    end else if (!stall) begin
      mValid    = id_valid;
      mRegwrite = id_regwrite & id_valid;
      mMemread  = id_memread & id_valid;
      mMemwrite = id_memwrite & id_valid;
      mMemtoreg = id_memtoreg & id_valid;
      mResult   = res;
      mStore    = b;
      mWreg     = id_wreg;
      mZero     = (res == 0);
    end
    #1;
    checkOutput(tag);
  endtask

  task automatic setOp(input logic [2:0] ctrl, input logic [RW-1:0] rs, input logic [RW-1:0] rt,
                       input logic [RW-1:0] wreg, input logic [DW-1:0] rsd,
                       input logic [DW-1:0] rtd, input logic rw);
    id_valid    = 1'b1;
    id_alu_ctrl = ctrl;
    id_rs       = rs;
    id_rt       = rt;
    id_wreg     = wreg;
    id_rs_data  = rsd;
    id_rt_data  = rtd;
    id_regwrite = rw;
    id_imm      = '0;
    id_shamt    = '0;
    id_alusrc   = 1'b0;
    id_memread  = 1'b0;
    id_memwrite = 1'b0;
    id_memtoreg = 1'b0;
  endtask

  logic [DW-1:0] opResults [7];
  logic [2:0]    opCodes   [7];
  logic [DW-1:0] heldResult;

  initial begin
    opCodes   = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111, 3'b011, 3'b100};
    opResults = '{32'hF0F0_00FF, 32'hF0EF_FF01, 32'h0, 32'hF0F0_00FF,
                  32'h0000_0FF0, 32'h0000_000F, 32'h0};
    rst_n = 1'b0;
    stall = 1'b0;
    flush = 1'b0;
    wb_regwrite = 1'b0;
    wb_wreg = '0;
    wb_data = '0;
    setOp(3'b010, 0, 0, 0, 0, 0, 0);
    modelClear();
    #12;
    checkOutput("por");
    @(negedge clk);
    rst_n = 1'b1;

    // Reset: first add, then async reset mid-stream while stalled.
    setOp(3'b010, 1, 2, 3, 5, 7, 1);
    applyStimulus("add5p7");
    chk("add5p7.value", exmem_alu_result, 32'd12);
    chk("add5p7.zflag", DW'(exmem_zero), 32'd0);
    stall = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    modelClear();
    checkOutput("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    stall = 1'b0;

    // Each ALU code on fixed operands; rs/rt not written so no forwarding occurs.
    for (int i = 0; i < 7; i++) begin
      setOp(opCodes[i], 6, 7, 8, 32'hF0F0_0000, 32'h0000_00FF, 0);
      id_shamt = 5'd4;
      applyStimulus($sformatf("alu%0d", i));
      chk($sformatf("alu%0d.const", i), exmem_alu_result, opResults[i]);
    end
    chk("code100.zflag", DW'(exmem_zero), 32'd1);

    // EX/MEM forwarding, EX/MEM priority over WB, WB-only, and register 0.
    setOp(3'b010, 1, 2, 3, 4, 6, 1);
    applyStimulus("fwd.add");
    setOp(3'b110, 3, 1, 4, 0, 4, 1);
    applyStimulus("fwd.sub");
    chk("fwd.sub.const", exmem_alu_result, 32'd6);
    setOp(3'b010, 1, 2, 3, 4, 6, 1);
    applyStimulus("fwd2.add");
    setOp(3'b110, 3, 1, 4, 0, 4, 1);
    wb_regwrite = 1'b1; wb_wreg = 3; wb_data = 99;
    applyStimulus("fwd.prio");
    chk("fwd.prio.const", exmem_alu_result, 32'd6);
    setOp(3'b110, 3, 1, 4, 0, 4, 1);
    applyStimulus("fwd.wbonly");
    chk("fwd.wbonly.const", exmem_alu_result, 32'd95);
    setOp(3'b010, 1, 2, 0, 5, 7, 1);
    wb_wreg = 0;
    applyStimulus("r0.write");
    setOp(3'b010, 0, 0, 9, 32'h11, 32'h22, 1);
    applyStimulus("r0.read");
    chk("r0.read.const", exmem_alu_result, 32'h33);
    wb_regwrite = 1'b0;

    // Load result in EX/MEM must not forward.
    setOp(3'b010, 1, 0, 5, 32'h40, 0, 1);
    id_memread = 1'b1; id_memtoreg = 1'b1;
    applyStimulus("ld");
    setOp(3'b010, 5, 0, 6, 3, 4, 1);
    applyStimulus("ld.use");
    chk("ld.use.const", exmem_alu_result, 32'd7);

    // Stall for three cycles with changing inputs, then flush+stall, then bubble.
    heldResult = exmem_alu_result;
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      setOp(3'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), $urandom, $urandom, 1);
      applyStimulus($sformatf("stall%0d", i));
      chk($sformatf("stall%0d.held", i), exmem_alu_result, heldResult);
    end
    flush = 1'b1;
    applyStimulus("flushstall");
    chk("flushstall.valid", DW'(exmem_valid), 32'd0);
    stall = 1'b0;
    flush = 1'b0;
    setOp(3'b001, 1, 2, 7, 32'hA0, 32'h0B, 1);
    id_valid = 1'b0; id_memwrite = 1'b1;
    applyStimulus("bubble");
    chk("bubble.data", exmem_alu_result, 32'hAB);

    // Store with immediate offset and forwarded store data.
    setOp(3'b010, 1, 2, 9, 32'hDE00, 32'h00AD, 1);
    applyStimulus("st.prod");
    setOp(3'b010, 8, 9, 0, 32'h100, 0, 0);
    id_alusrc = 1'b1; id_imm = 8; id_memwrite = 1'b1;
    applyStimulus("st");
    chk("st.addr", exmem_alu_result, 32'h108);
    chk("st.data", exmem_store_data, 32'hDEAD);
    chk("st.mw",   DW'(exmem_memwrite), 32'd1);

    // Randomized traffic on a small register set so forwarding hits often.
    for (int i = 0; i < 300; i++) begin
      setOp(3'($urandom), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            5'($urandom_range(0, 3)), $urandom, $urandom, 1'($urandom));
      id_valid    = ($urandom_range(0, 7) != 0);
      id_alusrc   = 1'($urandom);
      id_imm      = $urandom_range(0, 1) ? $urandom : 0;
      id_shamt    = 5'($urandom);
      id_memread  = ($urandom_range(0, 3) == 0);
      id_memwrite = 1'($urandom);
      id_memtoreg = 1'($urandom);
      wb_regwrite = 1'($urandom);
      wb_wreg     = 5'($urandom_range(0, 3));
      wb_data     = $urandom;
      stall       = ($urandom_range(0, 7) == 0);
      flush       = ($urandom_range(0, 11) == 0);
      applyStimulus($sformatf("rnd%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ex_stage.md
# ex_stage

Execute stage of the 5-stage MIPS pipeline. Takes ID/EX-registered operands, control bits and the 3-bit ALU operation code produced by the ALU control decoder. It resolves EX/MEM and MEM/WB forwarding, performs the ALU operation, and captures the result into the EX/MEM pipeline register. The EX/MEM register supports stall (hold) and flush (bubble insertion).

## Interface
Parameters:
- `DW`, 32, datapath width
- `RW`, 5, register-address width

Ports:
- `clk` in 1: pipeline clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `id_valid` in 1: the ID/EX slot holds a real instruction.
- `id_rs_data`, `id_rt_data` in DW: register-file read data.
- `id_imm` in DW: sign-extended immediate.
- `id_shamt` in 5: shift amount.
- `id_rs`, `id_rt` in RW: source register numbers.
- `id_wreg` in RW: destination register number.
- `id_alu_ctrl` in 3: ALU operation code.
- `id_alusrc`, `id_regwrite`, `id_memread`, `id_memwrite`, `id_memtoreg` in 1: control bits.
- `wb_regwrite` in 1, `wb_wreg` in RW, `wb_data` in DW: MEM/WB writeback, used for forwarding.
- `stall` in 1: hold the EX/MEM register.
- `flush` in 1: load a bubble into EX/MEM.
- `exmem_valid`, `exmem_regwrite`, `exmem_memread`, `exmem_memwrite`, `exmem_memtoreg` out 1: registered control bits.
- `exmem_alu_result` out DW: registered ALU result.
- `exmem_store_data` out DW: registered store data.
- `exmem_wreg` out RW: registered destination register.
- `exmem_zero` out 1: registered flag, set when the result equals 0.

## Operation
Forwarding for operand A (the rs side) is combinational, evaluated in this priority order:
- Use `exmem_alu_result` when all of the following hold: `exmem_valid`, `exmem_regwrite`, `!exmem_memread`, `exmem_wreg!=0`, and `exmem_wreg==id_rs`.
- Otherwise use `wb_data` when `wb_regwrite`, `wb_wreg!=0`, and `wb_wreg==id_rs`.
- Otherwise use `id_rs_data`.

Operand B forwarding (fwdB) is identical, comparing against `id_rt` and defaulting to `id_rt_data`.

Operand selection:
- ALU B input is `id_imm` when `id_alusrc=1`, otherwise fwdB.
- Store data is always fwdB.

ALU codes (arithmetic modulo 2^DW, no overflow trap):
- `010` add
- `110` sub (A−B)
- `000` AND
- `001` OR
- `111` sll: fwdB << `id_shamt`
- `011` srl: fwdB >> `id_shamt`, logical, zero-fill
- Any other code: result 0.

Zero flag is `(result==0)`.

EX/MEM register update on each rising `clk`, in priority order:
- `flush`: all control bits and `exmem_valid` go to 0. Data fields and `exmem_wreg` go to 0.
- `stall` (with `flush` low): all outputs hold their values.
- Otherwise, all fields load. Control bits are ANDed with `id_valid`, so an invalid slot writes a bubble.

## Timing
- While `rst_n` is low, all outputs are 0 (asynchronous). After `rst_n` rises, the first capture happens on the next rising edge.
- Latency: exactly 1 cycle from ID/EX inputs to EX/MEM outputs.
- Forwarding uses current-cycle EX/MEM outputs, so back-to-back dependent ALU instructions need no stall.
- Load-use stalls are generated upstream. EX/MEM never forwards a load result.
- EX/MEM and WB both matching the same register: EX/MEM wins (newer value).
- Register 0 never forwards, even if a write to $0 is in flight.
- While stalled, the held EX/MEM contents continue to drive forwarding.
- `flush` and `stall` high together: flush wins.
- `rst_n` asserted mid-operation: outputs clear immediately regardless of `stall`/`flush`.

## Test plan
1. **Reset.** Assert `rst_n=0` mid-stream with `stall=1` → all outputs 0 immediately. Release, then present add 5+7 → `exmem_alu_result=12` one cycle later, `exmem_zero=0`.
2. **ALU ops.** Per code, with A=0xF0F0_0000, B=0x0000_00FF, shamt=4:
   - add → 0xF0F0_00FF
   - sub → 0xF0EF_FF01
   - and → 0
   - or → 0xF0F0_00FF
   - sll → 0x0000_0FF0
   - srl → 0x0000_000F
   - code `100` → 0 with `exmem_zero=1`
3. **Forwarding.**
   - Issue `add $3=$1+$2` (giving 10), then `sub $4=$3−$1` where stale `id_rs_data=0` → result uses 10.
   - Repeat with WB also writing $3=99 → EX/MEM's value 10 still chosen.
   - WB-only match → 99 used.
   - `id_rs=0` with `exmem_wreg=0` → no forwarding.
4. **Load not forwarded.** EX/MEM holds a load to $5 (`memread=1`), next instruction reads $5 → `id_rs_data` used unchanged.
5. **Stall/flush.** With `stall=1` for 3 cycles and varying inputs → outputs constant. With `flush` and `stall` both high → `exmem_valid=0`, all control bits 0. With `id_valid=0` → bubble captured, but data fields load.
6. **Store path.** sw with `alusrc=1`, imm=8, base=0x100, forwarded rt=0xDEAD → `exmem_alu_result=0x108`, `exmem_store_data=0xDEAD`, `exmem_memwrite=1`.
